// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip memory between NUM_REQ
// Avalon-MM requesters; read data returns to its owner one cycle after accept.
module onchip_memory_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W/8-1:0] req_byteenable,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [DATA_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         mem_address,
    output logic [DATA_W/8-1:0]       mem_byteenable,
    output logic                      mem_chipselect,
    output logic                      mem_write,
    output logic [DATA_W-1:0]         mem_writedata,
    output logic                      mem_clken,
    input  logic [DATA_W-1:0]         mem_readdata
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
    logic [BE_W-1:0]   be_arr    [NUM_REQ];
    logic [DATA_W-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0] pending;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
            assign be_arr[gi]    = req_byteenable[gi*BE_W +: BE_W];
            assign wdata_arr[gi] = req_writedata[gi*DATA_W +: DATA_W];
            assign pending[gi]   = req_read[gi] | req_write[gi];
        end
    endgenerate

    logic [IDX_W-1:0]   last_reg, last_next;
    logic [NUM_REQ-1:0] rd_pend_reg, rd_pend_next;
    logic [NUM_REQ-1:0] grant_raw, grant;
    logic [IDX_W-1:0]   win_idx;
    logic               found;
    logic               grant_valid;
    logic               is_read;

    // Search starts one past the previous winner so every requester is reached
    // within NUM_REQ-1 cycles of continuous contention.
    always_comb begin
        int idx;
        grant_raw = '0;
        win_idx   = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_reg) + k) % NUM_REQ;
            if (!found && pending[idx]) begin
                found          = 1'b1;
                grant_raw[idx] = 1'b1;
                win_idx        = IDX_W'(idx);
            end
        end
    end

    // Nothing is accepted while reset is held, even with requests pending.
    assign grant_valid     = found & reset_n;
    assign grant           = grant_raw & {NUM_REQ{reset_n}};
    assign req_waitrequest = ~grant;

    assign mem_chipselect = grant_valid;
    assign mem_write      = grant_valid & req_write[win_idx];
    assign mem_address    = grant_valid ? addr_arr[win_idx]  : '0;
    assign mem_byteenable = grant_valid ? be_arr[win_idx]    : '0;
    assign mem_writedata  = grant_valid ? wdata_arr[win_idx] : '0;
    assign mem_clken      = reset_n;

    // Read+write together is a write only, so it must not schedule a return.
    assign is_read      = grant_valid & req_read[win_idx] & ~req_write[win_idx];
    assign rd_pend_next = is_read ? grant : '0;
    assign last_next    = grant_valid ? win_idx : last_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_reg    <= IDX_W'(NUM_REQ - 1);
            rd_pend_reg <= '0;
        end else begin
            last_reg    <= last_next;
            rd_pend_reg <= rd_pend_next;
        end
    end

    assign req_readdatavalid = rd_pend_reg;
    assign req_readdata      = mem_readdata;
endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Self-checking bench for onchip_memory_arbiter: directed scenarios plus a
// randomized run against a round-robin/memory reference model.
module tb_onchip_memory_arbiter;
    localparam int N  = 4;
    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic            clk;
    logic            reset_n;
    logic [N*AW-1:0] req_address;
    logic [N*BW-1:0] req_byteenable;
    logic [N-1:0]    req_read;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_writedata;
    logic [N-1:0]    req_waitrequest;
    logic [DW-1:0]   req_readdata;
    logic [N-1:0]    req_readdatavalid;
    logic [AW-1:0]   mem_address;
    logic [BW-1:0]   mem_byteenable;
    logic            mem_chipselect;
    logic            mem_write;
    logic [DW-1:0]   mem_writedata;
    logic            mem_clken;
    logic [DW-1:0]   mem_readdata;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_last = N - 1;

    onchip_memory_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_address(req_address), .req_byteenable(req_byteenable),
        .req_read(req_read), .req_write(req_write), .req_writedata(req_writedata),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken),
        .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: registered address, unregistered output, byte-enabled writes.
    logic [DW-1:0] mem_array [0:8191];
    logic [AW-1:0] mem_addr_q;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            for (int b = 0; b < BW; b++)
                if (mem_write && mem_byteenable[b])
                    mem_array[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            mem_addr_q <= mem_address;
        end
    end
    assign mem_readdata = mem_array[mem_addr_q];

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [BW-1:0] be,
                           input logic [DW-1:0] d);
        req_read[i]                = rd;
        req_write[i]               = wr;
        req_address[i*AW +: AW]    = a;
        req_byteenable[i*BW +: BW] = be;
        req_writedata[i*DW +: DW]  = d;
    endtask

    task automatic clear_all();
        req_read = '0; req_write = '0; req_address = '0;
        req_byteenable = '0; req_writedata = '0;
    endtask

    // Unopposed full write, accepted on the next edge.
    task automatic do_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_req(i, 1'b0, 1'b1, a, 4'hF, d);
        @(posedge clk); #1;
        clear_all();
        exp_last = i;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 13'h0, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (req_waitrequest !== 4'hF || mem_chipselect !== 1'b0 || mem_clken !== 1'b0 ||
            mem_write !== 1'b0 || req_readdatavalid !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: wait=%b cs=%b clken=%b wr=%b rv=%b required wait=1111 cs=0 clken=0 wr=0 rv=0000",
                     req_waitrequest, mem_chipselect, mem_clken, mem_write, req_readdatavalid);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_waitrequest !== 4'b1110 || mem_clken !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_grant: wait=%b clken=%b required wait=1110 clken=1",
                     req_waitrequest, mem_clken);
        end
        exp_last = 0;
        @(posedge clk); #1;
        clear_all();
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_return: rv=%b required 0001", req_readdatavalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        do_write(0, 13'h0010, 32'hDEADBEEF);
        set_req(2, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (req_waitrequest[2] !== 1'b0 || mem_address !== 13'h0010 ||
            mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL single_read_accept: wait=%b addr=%h cs=%b wr=%b required wait[2]=0 addr=0010 cs=1 wr=0",
                     req_waitrequest, mem_address, mem_chipselect, mem_write);
        end
        exp_last = 2;
        @(posedge clk); #1;
        clear_all();
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== 4'b0100 || req_readdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_read_return: rv=%b data=%h required rv=0100 data=deadbeef",
                     req_readdatavalid, req_readdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] prev_rv, oh;
        logic [DW-1:0] prev_data;
        int last_acc [N];
        int idx;
        for (int i = 0; i < N; i++) do_write(0, 13'(32'h20 + i), 32'h1000_0000 + i * 32'h1111);
        for (int i = 0; i < N; i++) begin
            set_req(i, 1'b1, 1'b0, 13'(32'h20 + i), 4'hF, 32'h0);
            last_acc[i] = -1;
        end
        prev_rv = '0; prev_data = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            idx = (exp_last + 1) % N;
            oh  = 4'(1 << idx);
            n_tests++;
            if (req_waitrequest !== ~oh) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d: wait=%b required %b", cyc, req_waitrequest, ~oh);
            end
            n_tests++;
            if (req_readdatavalid !== prev_rv || (prev_rv != 0 && req_readdata !== prev_data)) begin
                n_fail++;
                $display("FAIL rr_return cycle %0d: rv=%b data=%h required rv=%b data=%h",
                         cyc, req_readdatavalid, req_readdata, prev_rv, prev_data);
            end
            if (last_acc[idx] >= 0) begin
                n_tests++;
                if (cyc - last_acc[idx] != N) begin
                    n_fail++;
                    $display("FAIL rr_spacing req %0d: gap=%0d required %0d", idx, cyc - last_acc[idx], N);
                end
            end
            last_acc[idx] = cyc;
            prev_rv   = oh;
            prev_data = 32'h1000_0000 + idx * 32'h1111;
            exp_last  = idx;
            @(posedge clk); #1;
        end
        clear_all();
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== prev_rv || req_readdata !== prev_data) begin
            n_fail++;
            $display("FAIL rr_last_return: rv=%b data=%h required rv=%b data=%h",
                     req_readdatavalid, req_readdata, prev_rv, prev_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_byte_write();
        do_write(0, 13'h1FFF, 32'hAABBCCDD);
        set_req(1, 1'b0, 1'b1, 13'h1FFF, 4'b0011, 32'h11223344);
        @(negedge clk);
        n_tests++;
        if (req_waitrequest[1] !== 1'b0 || mem_write !== 1'b1 || mem_byteenable !== 4'b0011 ||
            mem_writedata !== 32'h11223344 || mem_address !== 13'h1FFF) begin
            n_fail++;
            $display("FAIL byte_write_port: wait=%b wr=%b be=%b wd=%h addr=%h required wait[1]=0 wr=1 be=0011 wd=11223344 addr=1fff",
                     req_waitrequest, mem_write, mem_byteenable, mem_writedata, mem_address);
        end
        exp_last = 1;
        @(posedge clk); #1;
        clear_all();
        set_req(3, 1'b1, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (req_waitrequest[3] !== 1'b0 || req_readdatavalid !== 4'h0) begin
            n_fail++;
            $display("FAIL byte_read_accept: wait=%b rv=%b required wait[3]=0 rv=0000",
                     req_waitrequest, req_readdatavalid);
        end
        exp_last = 3;
        @(posedge clk); #1;
        clear_all();
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== 4'b1000 || req_readdata !== 32'hAABB3344) begin
            n_fail++;
            $display("FAIL byte_merge: rv=%b data=%h required rv=1000 data=aabb3344",
                     req_readdatavalid, req_readdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rw_both();
        set_req(0, 1'b1, 1'b1, 13'h0030, 4'hF, 32'h5A5A1234);
        @(negedge clk);
        n_tests++;
        if (mem_write !== 1'b1 || mem_chipselect !== 1'b1 || req_waitrequest[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_both_write: wr=%b cs=%b wait=%b required wr=1 cs=1 wait[0]=0",
                     mem_write, mem_chipselect, req_waitrequest);
        end
        exp_last = 0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
        set_req(2, 1'b1, 1'b0, 13'h0030, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== 4'h0) begin
            n_fail++;
            $display("FAIL rw_both_no_return: rv=%b required 0000", req_readdatavalid);
        end
        exp_last = 2;
        @(posedge clk); #1;
        clear_all();
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== 4'b0100 || req_readdata !== 32'h5A5A1234) begin
            n_fail++;
            $display("FAIL rw_both_readback: rv=%b data=%h required rv=0100 data=5a5a1234",
                     req_readdatavalid, req_readdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_during_read();
        set_req(1, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (req_waitrequest[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_read_accept: wait=%b required wait[1]=0", req_waitrequest);
        end
        @(posedge clk); #1;
        clear_all();
        reset_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== 4'h0 || mem_chipselect !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_read_discard: rv=%b cs=%b required rv=0000 cs=0",
                     req_readdatavalid, mem_chipselect);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 13'h0010, 4'hF, 32'h0);
        @(negedge clk);
        n_tests++;
        if (req_waitrequest !== 4'b1110 || req_readdatavalid !== 4'h0) begin
            n_fail++;
            $display("FAIL rst_resume_grant: wait=%b rv=%b required wait=1110 rv=0000",
                     req_waitrequest, req_readdatavalid);
        end
        exp_last = 0;
        @(posedge clk); #1;
        clear_all();
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== 4'b0001 || req_readdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rst_resume_return: rv=%b data=%h required rv=0001 data=deadbeef",
                     req_readdatavalid, req_readdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [16];
        logic          act [N];
        logic          op_rd [N];
        logic          op_wr [N];
        logic [AW-1:0] op_a [N];
        logic [BW-1:0] op_be [N];
        logic [DW-1:0] op_d [N];
        int            wait_cnt [N];
        logic [N-1:0]  exp_rv, nrv, oh;
        logic [DW-1:0] exp_rd, nrd;
        logic          found;
        int            gi, idx, t;
        for (int a = 0; a < 16; a++) begin
            ref_mem[a] = $urandom;
            do_write(0, 13'(a), ref_mem[a]);
        end
        for (int i = 0; i < N; i++) begin act[i] = 1'b0; wait_cnt[i] = 0; end
        exp_rv = '0; exp_rd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!act[i] && $urandom_range(1, 0) == 1) begin
                    act[i]   = 1'b1;
                    t        = $urandom_range(9, 0);
                    op_rd[i] = (t < 5) || (t == 9);
                    op_wr[i] = (t >= 5);
                    op_a[i]  = 13'($urandom_range(15, 0));
                    op_be[i] = 4'($urandom_range(15, 1));
                    op_d[i]  = $urandom;
                    set_req(i, op_rd[i], op_wr[i], op_a[i], op_be[i], op_d[i]);
                end else if (!act[i]) begin
                    set_req(i, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0);
                end
            end
            @(negedge clk);
            found = 1'b0; gi = 0;
            for (int k = 1; k <= N; k++) begin
                idx = (exp_last + k) % N;
                if (!found && act[idx]) begin found = 1'b1; gi = idx; end
            end
            oh = found ? 4'(1 << gi) : 4'h0;
            n_tests++;
            if (req_waitrequest !== ~oh || mem_chipselect !== found ||
                mem_write !== (found && op_wr[gi]) ||
                (found && mem_address !== op_a[gi]) ||
                (found && op_wr[gi] && (mem_byteenable !== op_be[gi] || mem_writedata !== op_d[gi]))) begin
                n_fail++;
                $display("FAIL rand_port cycle %0d: wait=%b cs=%b wr=%b addr=%h be=%b wd=%h required wait=%b cs=%b wr=%b addr=%h be=%b wd=%h",
                         cyc, req_waitrequest, mem_chipselect, mem_write, mem_address, mem_byteenable,
                         mem_writedata, ~oh, found, found && op_wr[gi], op_a[gi], op_be[gi], op_d[gi]);
            end
            n_tests++;
            if (req_readdatavalid !== exp_rv || (exp_rv != 0 && req_readdata !== exp_rd)) begin
                n_fail++;
                $display("FAIL rand_return cycle %0d: rv=%b data=%h required rv=%b data=%h",
                         cyc, req_readdatavalid, req_readdata, exp_rv, exp_rd);
            end
            nrv = '0; nrd = '0;
            for (int i = 0; i < N; i++)
                if (act[i] && !(found && i == gi)) wait_cnt[i]++;
            if (found) begin
                n_tests++;
                if (wait_cnt[gi] > N - 1) begin
                    n_fail++;
                    $display("FAIL rand_latency req %0d: waited %0d required <= %0d", gi, wait_cnt[gi], N - 1);
                end
                wait_cnt[gi] = 0;
                if (op_wr[gi]) begin
                    for (int b = 0; b < BW; b++)
                        if (op_be[gi][b]) ref_mem[op_a[gi][3:0]][b*8 +: 8] = op_d[gi][b*8 +: 8];
                end else begin
                    nrv = oh;
                    nrd = ref_mem[op_a[gi][3:0]];
                end
                exp_last = gi;
            end
            @(posedge clk); #1;
            if (found) act[gi] = 1'b0;
            exp_rv = nrv; exp_rd = nrd;
        end
        clear_all();
        @(negedge clk);
        n_tests++;
        if (req_readdatavalid !== exp_rv || (exp_rv != 0 && req_readdata !== exp_rd)) begin
            n_fail++;
            $display("FAIL rand_final_return: rv=%b data=%h required rv=%b data=%h",
                     req_readdatavalid, req_readdata, exp_rv, exp_rd);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset_n = 1'b0;
        clear_all();
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_byte_write();
        test_rw_both();
        test_reset_during_read();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
